// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed seven-segment display driver. Scans
//               NUM_DIGITS digits, one per REFRESH_DIV-cycle slot. Each slot
//               starts with BLANK_CYCLES of all-anodes-off (anti-ghosting).
//               Loaded digit values go through a pending/active double buffer
//               that only swaps at a frame boundary, so a frame never tears.
// Optional    : define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero
//               digits (digit 0 is always shown).
// Ports       : clk        - system clock
//               reset_n    - asynchronous active-low reset
//               enable     - scan run; low freezes the scan and darkens
//               load       - capture strobe for digits_in / dp_in
//               digits_in  - packed hex digits, digit i = [4i+3:4i]
//               dp_in      - decimal point per digit
//               seg        - segments, bit order gfedcba
//               dp         - decimal point
//               an         - digit enables, an[i] selects digit i
//               frame_done - one-cycle pulse after the frame wrap
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] c_P_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] c_IDX_LAST = IW'(NUM_DIGITS - 1);

  // Inactive output levels; XOR with these also applies the polarity.
  localparam logic [6:0]            c_SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic                  c_DP_OFF  = (ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] c_AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PW-1:0]           p_q, p_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                  w_p_wrap;
  logic                  w_frame_wrap;
  logic                  w_blank;
  logic                  w_lz_blank;
  logic                  w_lit;
  logic [3:0]            w_dig;
  logic                  w_dp_bit;
  logic [NUM_DIGITS-1:0] w_sel;

  assign w_p_wrap     = (p_q == c_P_LAST);
  // Frame wrap only exists while scanning; a frozen scan never wraps.
  assign w_frame_wrap = enable && w_p_wrap && (idx_q == c_IDX_LAST);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank = 1'b0;
    end else begin : g_blank
      assign w_blank = (p_q < PW'(BLANK_CYCLES));
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz_mask;
  logic                  w_lz_run;

  // Walk down from the top digit; the run of blanked digits ends at the
  // first nonzero value or set decimal point. Digit 0 is never blanked.
  always_comb begin
    w_lz_run  = 1'b1;
    w_lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_lz_run     = w_lz_run && (act_dig_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      w_lz_mask[i] = w_lz_run;
    end
  end

  assign w_lz_blank = w_lz_mask[idx_q];
`else
  assign w_lz_blank = 1'b0;
`endif

  assign w_dig    = act_dig_q[{idx_q, 2'b00} +: 4];
  assign w_dp_bit = act_dp_q[idx_q];
  assign w_lit    = enable && !w_blank && !w_lz_blank;

  always_comb begin
    w_sel        = '0;
    w_sel[idx_q] = 1'b1;
  end

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Prescaler and scan index
  // --------------------------------------------------------------------------
  always_comb begin
    p_d   = p_q;
    idx_d = idx_q;
    if (enable) begin
      if (w_p_wrap) begin
        p_d   = '0;
        idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Double buffer. A load on the wrap cycle bypasses pending so it shows in
  // the very next frame instead of one frame later.
  // --------------------------------------------------------------------------
  always_comb begin
    pend_dig_d  = pend_dig_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    if (w_frame_wrap) begin
      if (load) begin
        act_dig_d   = digits_in;
        act_dp_d    = dp_in;
        pend_dig_d  = digits_in;
        pend_dp_d   = dp_in;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        act_dig_d   = pend_dig_q;
        act_dp_d    = pend_dp_q;
        pend_flag_d = 1'b0;
      end
    end else if (load) begin
      pend_dig_d  = digits_in;
      pend_dp_d   = dp_in;
      pend_flag_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: registered from the current (idx, p), one cycle behind.
  // Segments are also darkened while the anodes are off.
  // --------------------------------------------------------------------------
  always_comb begin
    seg_d        = c_SEG_OFF;
    dp_d         = c_DP_OFF;
    an_d         = c_AN_OFF;
    frame_done_d = w_frame_wrap;
    if (w_lit) begin
      seg_d = f_decode(w_dig) ^ c_SEG_OFF;
      dp_d  = w_dp_bit ^ c_DP_OFF;
      an_d  = w_sel ^ c_AN_OFF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q          <= '0;
      idx_q        <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      seg_q        <= c_SEG_OFF;
      dp_q         <= c_DP_OFF;
      an_q         <= c_AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      p_q          <= p_d;
      idx_q        <= idx_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with
//               NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-low
//               seg/an. Expected values are hand-computed. `cyc` counts
//               clock edges since the last reset release; after edge n the
//               outputs reflect scan position n-1 (p = pos%4, idx = pos/4%4)
//               unless the scan was frozen. Leading-zero expectations follow
//               SEG7_LEADING_ZERO_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  seg7_scan_driver #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .ACTIVE_LOW_SEG (1),
    .ACTIVE_LOW_AN  (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    dp_in     = 4'h0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an",  {12'h0, an},  16'h000F);
    chk("rst_seg", {9'h0, seg},  16'h007F);
    chk("rst_dp",  {15'h0, dp},  16'h0001);
    chk("rst_fd",  {15'h0, frame_done}, 16'h0000);

    reset_n = 1'b1;
    enable  = 1'b1;
    cyc     = 0;

    // ---------------- 1: idle scan shows zeros ----------------
    run_to(1);  chk("t1_blank_an", {12'h0, an}, 16'h000F);
    run_to(2);  chk("t1_d0_an",    {12'h0, an}, 16'h000E);
    chk("t1_d0_seg", {9'h0, seg}, 16'h0040);
    chk("t1_d0_dp",  {15'h0, dp}, 16'h0001);

    // 2: load 1234 mid-first-frame; must not show until frame 2
    load = 1'b1; digits_in = 16'h1234; dp_in = 4'h0;
    run_to(3);
    load = 1'b0;
    run_to(6);  chk("t1_d1_an",  {12'h0, an},  16'h000D);
    chk("t1_d1_seg", {9'h0, seg}, 16'h0040);
    run_to(14); chk("t2_old_d3_an",  {12'h0, an},  16'h0007);
    chk("t2_old_d3_seg", {9'h0, seg}, 16'h0040);
    run_to(15); chk("t1_fd_low", {15'h0, frame_done}, 16'h0000);
    run_to(16); chk("t1_fd_hi",  {15'h0, frame_done}, 16'h0001);
    run_to(17); chk("t1_fd_one", {15'h0, frame_done}, 16'h0000);
    chk("t2_blank_an", {12'h0, an}, 16'h000F);
    run_to(18); chk("t2_d0_an",  {12'h0, an},  16'h000E);
    chk("t2_d0_seg", {9'h0, seg}, 16'h0019);
    run_to(26); chk("t2_d2_an",  {12'h0, an},  16'h000B);
    chk("t2_d2_seg", {9'h0, seg}, 16'h0024);
    run_to(30); chk("t2_d3_an",  {12'h0, an},  16'h0007);
    chk("t2_d3_seg", {9'h0, seg}, 16'h0079);
    run_to(32); chk("t1_fd_period", {15'h0, frame_done}, 16'h0001);

    // ---------------- 3: mid-frame load at idx=1 ----------------
    run_to(36);
    load = 1'b1; digits_in = 16'hABCD;
    run_to(37);
    load = 1'b0;
    run_to(42); chk("t3_d2_old_an",  {12'h0, an},  16'h000B);
    chk("t3_d2_old_seg", {9'h0, seg}, 16'h0024);
    run_to(50); chk("t3_d0_new_an",  {12'h0, an},  16'h000E);
    chk("t3_d0_new_seg", {9'h0, seg}, 16'h0021);

    // ---------------- 4: load on the frame-wrap cycle ----------------
    run_to(63);
    load = 1'b1; digits_in = 16'h00F0;
    run_to(64);
    load = 1'b0;
    chk("t4_fd", {15'h0, frame_done}, 16'h0001);
    run_to(66); chk("t4_d0_seg", {9'h0, seg}, 16'h0040);
    run_to(70); chk("t4_d1_an",  {12'h0, an},  16'h000D);
    chk("t4_d1_seg", {9'h0, seg}, 16'h000E);

    // ---------------- 5: freeze at idx=2, p=2 ----------------
    run_to(90);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_hold_an", {12'h0, an}, 16'h000F);
      chk("t5_hold_fd", {15'h0, frame_done}, 16'h0000);
    end
    enable = 1'b1;
    run_to(101); chk("t5_resume_an",  {12'h0, an},  16'h000B);
    chk("t5_resume_seg", {9'h0, seg}, 16'h0040);
    run_to(103); chk("t5_d3_blank", {12'h0, an}, 16'h000F);
    run_to(104); chk("t5_d3_an",    {12'h0, an}, 16'h0007);
    run_to(105); chk("t5_fd_low",   {15'h0, frame_done}, 16'h0000);
    run_to(106); chk("t5_fd_hi",    {15'h0, frame_done}, 16'h0001);

    // reset pulse mid-frame: asynchronous, seen before the next edge
    run_to(108);
    reset_n = 1'b0;
    #2;
    chk("t5_rst_an",  {12'h0, an},  16'h000F);
    chk("t5_rst_seg", {9'h0, seg},  16'h007F);
    chk("t5_rst_fd",  {15'h0, frame_done}, 16'h0000);
    tick();
    reset_n = 1'b1;
    cyc     = 0;
    run_to(1); chk("t5_post_blank", {12'h0, an}, 16'h000F);
    run_to(2); chk("t5_post_d0_an",  {12'h0, an},  16'h000E);
    chk("t5_post_d0_seg", {9'h0, seg}, 16'h0040);
    run_to(6); chk("t5_post_d1_an",  {12'h0, an},  16'h000D);
    chk("t5_post_d1_seg", {9'h0, seg}, 16'h0040);

    // ---------------- 6: leading-zero blanking ----------------
    run_to(7);
    load = 1'b1; digits_in = 16'h0050; dp_in = 4'h0;
    run_to(8);
    load = 1'b0;
    run_to(18); chk("t6_d0_an",  {12'h0, an},  16'h000E);
    chk("t6_d0_seg", {9'h0, seg}, 16'h0040);
    run_to(22); chk("t6_d1_an",  {12'h0, an},  16'h000D);
    chk("t6_d1_seg", {9'h0, seg}, 16'h0012);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_to(26); chk("t6_d2_an",      {12'h0, an}, 16'h000F);
    run_to(28); chk("t6_d2_late_an", {12'h0, an}, 16'h000F);
    run_to(30); chk("t6_d3_an",      {12'h0, an}, 16'h000F);
`else
    run_to(26); chk("t6_d2_an",  {12'h0, an},  16'h000B);
    chk("t6_d2_seg", {9'h0, seg}, 16'h0040);
    run_to(30); chk("t6_d3_an",  {12'h0, an},  16'h0007);
    chk("t6_d3_seg", {9'h0, seg}, 16'h0040);
`endif

    // dp on digit 2 stops the blanking run and lights the decimal point
    run_to(33);
    load = 1'b1; digits_in = 16'h0000; dp_in = 4'b0100;
    run_to(34);
    load = 1'b0;
    run_to(54); chk("t6b_d1_an",  {12'h0, an},  16'h000D);
    chk("t6b_d1_dp",  {15'h0, dp}, 16'h0001);
    run_to(58); chk("t6b_d2_an",  {12'h0, an},  16'h000B);
    chk("t6b_d2_seg", {9'h0, seg}, 16'h0040);
    chk("t6b_d2_dp",  {15'h0, dp}, 16'h0000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    run_to(62); chk("t6b_d3_an", {12'h0, an}, 16'h000F);
`else
    run_to(62); chk("t6b_d3_an", {12'h0, an}, 16'h0007);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed cyc %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Time-multiplexed seven-segment display driver. It sits directly downstream of the team's cascaded modulo counters and takes their packed 4-bit digit values. It scans NUM_DIGITS common-anode/cathode digits at a rate set by a refresh prescaler. Captured values are double-buffered so a display frame never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be >= 2.
REFRESH_DIV, 50000, clk cycles per digit slot; must be > BLANK_CYCLES.
BLANK_CYCLES, 16, anti-ghosting cycles at the start of each slot during which all anodes are off; may be 0.
ACTIVE_LOW_SEG, 1, 1 = segment and dp outputs are active-low.
ACTIVE_LOW_AN, 1, 1 = anode outputs are active-low.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
enable  input  1  scan run; low = freeze and darken
load  input  1  capture strobe for digits_in/dp_in
digits_in  input  4*NUM_DIGITS  packed hex digits; digit i = [4i+3:4i]
dp_in  input  NUM_DIGITS  decimal point per digit
seg  output  7  segments, bit order gfedcba
dp  output  1  decimal point
an  output  NUM_DIGITS  digit enables; an[i] selects digit i
frame_done  output  1  one-cycle pulse at frame wrap

Behaviour:
- Reset (async, reset_n low):
  - prescaler p = 0, scan index idx = 0.
  - pending and active buffers = 0; pending flag = 0.
  - seg, dp and an all at the inactive level; frame_done = 0.
- Widths: p is $clog2(REFRESH_DIV) bits; idx is max(1, $clog2(NUM_DIGITS)) bits.
- Prescaler (enable = 1):
  - p counts 0..REFRESH_DIV-1, then wraps to 0.
  - On a wrap, idx advances 0,1,...,NUM_DIGITS-1, then wraps to 0.
- Frame wrap: the cycle where p = REFRESH_DIV-1 and idx = NUM_DIGITS-1.
  - frame_done is registered high for exactly the following cycle.
  - Period is NUM_DIGITS*REFRESH_DIV cycles.
- Double buffer:
  - load = 1 captures digits_in/dp_in into the pending buffer and sets the pending flag. The latest load wins.
  - On frame wrap with the pending flag set: pending is copied to active and the flag is cleared.
  - load on the frame-wrap cycle itself: digits_in/dp_in go directly to active and the flag is cleared.
  - Result: a mid-frame load is never visible until the next frame starts at idx 0.
- Output registers, 1-cycle latency from (idx, p):
  - If p < BLANK_CYCLES: all an inactive.
  - Otherwise: only an[idx] is active; seg = decode(active digit idx); dp = active dp[idx].
  - Polarity is applied per the ACTIVE_LOW_* parameters.
- Decode (active-high, gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- enable = 0:
  - p, idx and the buffers hold; loads are still accepted into pending.
  - an is inactive from the next cycle; frame_done = 0.
  - On re-enable, scanning resumes from the held p/idx.
- Reset mid-frame: all state returns to reset values immediately. The first frame after reset shows all zeros unless a load occurred.

Optional Feature:
Macro SEG7_LEADING_ZERO_BLANK_EN.
- Defined: leading-zero blanking.
  - Digits from NUM_DIGITS-1 downward whose active value is 0 and whose dp is 0 are blanked; their an stays inactive for the whole slot.
  - Blanking stops at the first nonzero digit or set dp.
  - Digit 0 is never blanked.
  - Slot timing and frame_done are unchanged.
- Undefined: every digit is always displayed.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, active-low seg/an.
1. Reset, enable=1, no load -> an=1111 for the first p=0 cycle. Then an=1110 with seg=7'h40 ("0" inverted). frame_done pulses every 16 cycles.
2. load with digits_in=16'h1234, dp_in=0 before frame start -> digit-0 slot shows seg=7'h19 ("4") with an=1110. Digit 3 shows seg=7'h79 ("1") with an=0111. Each slot has 1 blank cycle (an=1111) followed by 3 lit cycles.
3. Mid-frame (idx=1) load of 16'hABCD -> digit 2 still shows "2" (seg=7'h24) in this frame. Digit 0 shows "D" (seg=7'h21) at the next frame.
4. load asserted exactly on the frame-wrap cycle with 16'h00F0 -> the next frame's digit 1 shows "F" (seg=7'h0E). No one-frame delay.
5. enable=0 at idx=2, p=2 for 10 cycles -> an=1111 and frame_done=0 throughout. On re-enable, scanning resumes at idx=2, p=2. A reset_n pulse mid-frame forces an=1111, seg=7'h7F, idx=0.
6. SEG7_LEADING_ZERO_BLANK_EN defined, digits_in=16'h0050, dp_in=0 -> digits 3 and 2 stay an inactive all slot. Digit 1 shows "5" (seg=7'h12). Digit 0 shows "0". With the macro undefined, all four digits are lit.
